// File: rtl/spu_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
package spu_loader_pkg;

    // Instruction memory depth in 32-bit words and its word-address width.
    localparam int IMEM_DEPTH = 2048;
    localparam int ADDR_W     = 11;

    // Number of header (count) bytes that precede the instruction bytes.
    localparam int HDR_LEN    = 2;

    // Loader session states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a stream of bytes (most significant byte first) into 32-bit words.
// The three earlier bytes sit in a shift register and the incoming byte
// completes the word, so 'word' is valid in the same cycle 'full' is high.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        full,
    output logic [31:0] word
);

    logic [23:0] shreg_q, shreg_d;
    logic [1:0]  idx_q, idx_d;

    // Next shift-register contents and byte index.
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (clear) begin
            shreg_d = 24'h00_0000;
            idx_d   = 2'd0;
        end else if (push) begin
            shreg_d = {shreg_q[15:0], din};
            idx_d   = idx_q + 2'd1;
        end else begin
            shreg_d = shreg_q;
            idx_d   = idx_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= 24'h00_0000;
            idx_q   <= 2'd0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign full = push && !clear && (idx_q == 2'd3);
    assign word = {shreg_q, din};

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream (count, instruction bytes, XOR checksum) into the
// instruction memory while holding the CPU in reset.
module imem_loader
    import spu_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = spu_loader_pkg::IMEM_DEPTH,
    parameter int ADDR_W     = spu_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [15:0]       DEPTH16  = 16'(IMEM_DEPTH);
    localparam logic [ADDR_W:0]   WL_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    loader_state_e     state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [ADDR_W:0]   words_left_q, words_left_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer_s;
    logic              begin_s;
    logic              push_s;
    logic              pack_full_s;
    logic [31:0]       pack_word_s;
    logic [15:0]       count_s;

    assign xfer_s  = byte_valid && ready_q;
    assign begin_s = start && (state_q == ST_IDLE);
    assign push_s  = xfer_s && (state_q == ST_DATA);
    assign count_s = {cnt_hi_q, byte_data};

    byte_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .clear (begin_s),
        .push  (push_s),
        .din   (byte_data),
        .full  (pack_full_s),
        .word  (pack_word_s)
    );

    // Session FSM with count latch, remaining-word counter and checksum.
    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        words_left_d = words_left_q;
        csum_d       = csum_q;
        case (state_q)
            ST_IDLE: begin
                if (begin_s) begin
                    state_d      = ST_CNT_HI;
                    cnt_hi_d     = 8'h00;
                    words_left_d = '0;
                    csum_d       = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT_HI: begin
                if (xfer_s) begin
                    cnt_hi_d = byte_data;
                    state_d  = ST_CNT_LO;
                end else begin
                    state_d = ST_CNT_HI;
                end
            end
            ST_CNT_LO: begin
                if (xfer_s && (count_s >= 16'd1) && (count_s <= DEPTH16)) begin
                    words_left_d = count_s[ADDR_W:0];
                    state_d      = ST_DATA;
                end else if (xfer_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_CNT_LO;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    csum_d = csum_q ^ byte_data;
                end else begin
                    csum_d = csum_q;
                end
                if (pack_full_s) begin
                    words_left_d = words_left_q - WL_ONE;
                    state_d      = (words_left_q == WL_ONE) ? ST_CSUM : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; flags follow the next state.
    always_comb begin
        we_d    = pack_full_s;
        wdata_d = pack_full_s ? pack_word_s : wdata_q;
        if (begin_s) begin
            addr_d = '0;
        end else if (we_q && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + ADDR_ONE;
        end else begin
            addr_d = addr_q;
        end
        ready_d = (state_d == ST_CNT_HI) || (state_d == ST_CNT_LO) ||
                  (state_d == ST_DATA)   || (state_d == ST_CSUM);
        hold_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end else if (begin_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_hi_q     <= 8'h00;
            words_left_q <= '0;
            csum_q       <= 8'h00;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            we_q         <= 1'b0;
            ready_q      <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            words_left_q <= words_left_d;
            csum_q       <= csum_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            ready_q      <= ready_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, error, boundary and reset cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [10:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          done_cnt = 0;
    int          hold_gap = 0;

    always #5 clk = ~clk;

    imem_loader #(.IMEM_DEPTH(2048), .ADDR_W(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    // Log every write strobe cycle and every done pulse.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (load_done) begin
            done_cnt++;
            if (!cpu_hold) hold_gap++;
        end
    end

    function automatic logic [7:0] pat(input int j);
        return 8'((j * 37 + 5) & 255);
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        hold_gap = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_ready_timeout: byte_ready=%0b, required 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (cpu_hold && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_hold_timeout: cpu_hold=%0b, required 0", tag, cpu_hold);
        end
        repeat (2) @(negedge clk);
    endtask

    // Checks that the two-word example stream landed at addresses 0 and 1.
    task automatic check_two_words(input string tag);
        n_cmp++;
        if (wr_addr.size() !== 2) begin
            n_bad++;
            $display("FAIL %s_nwrites: got %0d, required 2", tag, wr_addr.size());
        end else begin
            if (wr_addr[0] !== 11'h000 || wr_data[0] !== 32'h1122_3344) begin
                n_bad++;
                $display("FAIL %s_write0: got %h@%h, required 11223344@000", tag, wr_data[0], wr_addr[0]);
            end
            n_cmp++;
            if (wr_addr[1] !== 11'h001 || wr_data[1] !== 32'hAABB_CCDD) begin
                n_bad++;
                $display("FAIL %s_write1: got %h@%h, required aabbccdd@001", tag, wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({byte_ready, imem_we, load_done, load_error, cpu_hold} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {byte_ready, imem_we, load_done, load_error, cpu_hold});
        end
        n_cmp++;
        if (imem_addr !== 11'h000 || imem_wdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL reset_bus: got addr %h data %h, required 000 00000000", imem_addr, imem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Checksum of 11 22 33 44 AA BB CC DD is 0x44.
    task automatic test_normal();
        logic [7:0] s [$];
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        clear_log();
        pulse_start();
        n_cmp++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_after_start: hold=%0b ready=%0b, required 1 1", cpu_hold, byte_ready);
        end
        foreach (s[i]) send_byte(s[i]);
        wait_end("normal");
        check_two_words("normal");
        n_cmp++;
        if (done_cnt !== 1 || hold_gap !== 0 || load_error !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_done: done=%0d hold_gap=%0d err=%0b, required 1 0 0", done_cnt, hold_gap, load_error);
        end
    endtask

    task automatic test_bad_count();
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        wait_end("badcnt");
        n_cmp++;
        if (load_error !== 1'b1 || wr_addr.size() !== 0 || done_cnt !== 0) begin
            n_bad++;
            $display("FAIL badcnt: err=%0b writes=%0d done=%0d, required 1 0 0", load_error, wr_addr.size(), done_cnt);
        end
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL badcnt_ready_idle: got %0b, required 0", byte_ready);
        end
    endtask

    task automatic test_count_overflow();
        clear_log();
        pulse_start();
        n_cmp++;
        if (load_error !== 1'b0) begin
            n_bad++;
            $display("FAIL error_clear_on_start: got %0b, required 0", load_error);
        end
        send_byte(8'h08);
        send_byte(8'h01);
        wait_end("ovf");
        n_cmp++;
        if (load_error !== 1'b1 || wr_addr.size() !== 0) begin
            n_bad++;
            $display("FAIL count_0801: err=%0b writes=%0d, required 1 0", load_error, wr_addr.size());
        end
    endtask

    task automatic test_max_count();
        logic [7:0]  cs;
        logic [31:0] first_w, last_w;
        int          seq_bad;
        cs = 8'h00;
        clear_log();
        pulse_start();
        send_byte(8'h08);
        send_byte(8'h00);
        for (int j = 0; j < 8192; j++) begin
            cs = cs ^ pat(j);
            send_byte(pat(j));
        end
        send_byte(cs);
        wait_end("max");
        first_w = {pat(0), pat(1), pat(2), pat(3)};
        last_w  = {pat(8188), pat(8189), pat(8190), pat(8191)};
        n_cmp++;
        if (wr_addr.size() !== 2048) begin
            n_bad++;
            $display("FAIL max_nwrites: got %0d, required 2048", wr_addr.size());
        end else begin
            seq_bad = 0;
            for (int k = 0; k < 2048; k++) if (wr_addr[k] !== 11'(k)) seq_bad++;
            n_cmp++;
            if (seq_bad !== 0) begin
                n_bad++;
                $display("FAIL max_addr_seq: %0d out of order, required 0", seq_bad);
            end
            n_cmp++;
            if (wr_addr[2047] !== 11'h7FF || wr_data[2047] !== last_w || wr_data[0] !== first_w) begin
                n_bad++;
                $display("FAIL max_last_write: got %h@%h first %h, required %h@7ff first %h",
                         wr_data[2047], wr_addr[2047], wr_data[0], last_w, first_w);
            end
        end
        n_cmp++;
        if (done_cnt !== 1 || load_error !== 1'b0) begin
            n_bad++;
            $display("FAIL max_done: done=%0d err=%0b, required 1 0", done_cnt, load_error);
        end
    endtask

    task automatic test_csum_mismatch();
        logic [7:0] s [$];
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        clear_log();
        pulse_start();
        foreach (s[i]) send_byte(s[i]);
        wait_end("csum");
        check_two_words("csum");
        n_cmp++;
        if (load_error !== 1'b1 || done_cnt !== 0) begin
            n_bad++;
            $display("FAIL csum_err: err=%0b done=%0d, required 1 0", load_error, done_cnt);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] s [$];
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        clear_log();
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        pulse_start();
        foreach (s[i]) begin
            send_byte(s[i]);
            if (i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        wait_end("gap");
        check_two_words("gap");
        n_cmp++;
        if (done_cnt !== 1 || load_error !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_done: done=%0d err=%0b, required 1 0", done_cnt, load_error);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s [$];
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        clear_log();
        pulse_start();
        foreach (s[i]) send_byte(s[i]);
        reset      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hBB;
        @(negedge clk);
        n_cmp++;
        if ({byte_ready, imem_we, load_done, load_error, cpu_hold} !== 5'b00000 ||
            imem_addr !== 11'h000 || imem_wdata !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL midreset_outputs: flags=%b addr=%h data=%h, required 00000 000 00000000",
                     {byte_ready, imem_we, load_done, load_error, cpu_hold}, imem_addr, imem_wdata);
        end
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_addr.size() !== 1) begin
            n_bad++;
            $display("FAIL midreset_writes: got %0d, required 1", wr_addr.size());
        end
        test_normal();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_count();
        test_count_overflow();
        test_max_count();
        test_csum_mismatch();
        test_gapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
